// File: rtl/comp_divider.sv
// comp_divider: sequential unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk        - rising-edge clock
//   Reset      - asynchronous active-low reset
//   Run        - start request, honoured in IDLE or DONE
//   Dividend   - unsigned dividend, captured on the start edge
//   Divisor    - unsigned divisor, captured on the start edge
//   Quotient   - quotient, meaningful while Ready=1
//   Remainder  - remainder, meaningful while Ready=1
//   Ready      - result valid, held until the next start or reset
//   Busy       - high during the WIDTH iteration cycles
//   DivByZero  - captured divisor was zero, valid with Ready
//
// State table:
//   state  | meaning
//   IDLE   | waiting for the first Run after reset
//   ITER   | shifting/subtracting, one quotient bit per clock
//   DONE   | result held on the outputs, Run starts the next operation
module comp_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Ready,
    output logic             Busy,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               dbz_q, dbz_d;

    logic [2*WIDTH-1:0] shifted;
    logic [WIDTH:0]     trial;
    logic               start;
    logic               last_iter;

    // State and datapath registers
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    // Run is ignored while iterating, so operands only enter on a real start.
    assign start     = Run && (state_q != S_ITER);
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // Trial subtract on the shifted partial remainder; the extra top bit is
    // the borrow. The shift never drops a set bit: before the final shift the
    // partial remainder is below 2^(WIDTH-1).
    assign shifted = {r_q[2*WIDTH-2:0], 1'b0};
    assign trial   = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, d_q};

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ITER;
            S_ITER:  if (last_iter) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_ITER;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        r_d   = r_q;
        d_d   = d_q;
        cnt_d = cnt_q;
        dbz_d = dbz_q;
        if (start) begin
            r_d   = {{WIDTH{1'b0}}, Dividend};
            d_d   = Divisor;
            dbz_d = (Divisor == '0);
            cnt_d = '0;
        end else if (state_q == S_ITER) begin
            if (!trial[WIDTH]) begin
                r_d = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
            end else begin
                r_d = shifted;
            end
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Outputs
    always_comb begin
        Quotient  = r_q[WIDTH-1:0];
        Remainder = r_q[2*WIDTH-1:WIDTH];
        Busy      = (state_q == S_ITER);
        Ready     = (state_q == S_DONE);
        DivByZero = dbz_q;
    end

endmodule

// File: tb/tb_comp_divider.sv
module tb_comp_divider;

    localparam int W = 32;

    logic         clk;
    logic         Reset;
    logic         Run;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Ready;
    logic         Busy;
    logic         DivByZero;

    int total = 0;
    int bad   = 0;

    comp_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Run       (Run),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Ready     (Ready),
        .Busy      (Busy),
        .DivByZero (DivByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dsr;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called after the start edge; counts edges until Ready, start edge = 1.
    task automatic wait_ready(input string nm);
        int edges;
        int busy_cnt;
        edges    = 1;
        busy_cnt = 0;
        while (!Ready && edges < 45) begin
            @(posedge clk);
            #1;
            edges++;
            if (!Ready && Busy) busy_cnt++;
        end
        check({nm, " latency"}, 64'(edges), 64'd33);
        check({nm, " busy cycles"}, 64'(busy_cnt), 64'd31);
        check({nm, " busy at done"}, 64'(Busy), 64'd0);
    endtask

    task automatic do_div(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        @(negedge clk);
        Run      = 1'b1;
        Dividend = a;
        Divisor  = b;
        @(posedge clk);
        #1;
        check({nm, " start busy"}, 64'(Busy), 64'd1);
        check({nm, " start ready"}, 64'(Ready), 64'd0);
        Run      = 1'b0;
        Dividend = ~a;
        Divisor  = ~b;
        wait_ready(nm);
        check({nm, " quotient"}, 64'(Quotient), 64'(eq));
        check({nm, " remainder"}, 64'(Remainder), 64'(er));
        check({nm, " divbyzero"}, 64'(DivByZero), 64'(edbz));
    endtask

    initial begin
        logic [W-1:0] a, b, eq, er;
        logic         edbz;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
        vecs[2]  = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
        vecs[3]  = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
        vecs[4]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[5]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
        vecs[6]  = '{32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,          1'b1};
        vecs[7]  = '{32'd7,          32'd7,          32'd1,          32'd0,          1'b0};
        vecs[8]  = '{32'h80000000,   32'd2,          32'h40000000,   32'd0,          1'b0};
        vecs[9]  = '{32'hFFFFFFFF,   32'h80000001,   32'd1,          32'h7FFFFFFE,   1'b0};
        vecs[10] = '{32'd12345,      32'd67,         32'd184,        32'd17,         1'b0};
        vecs[11] = '{32'd1000,       32'd3,          32'd333,        32'd1,          1'b0};
        vecs[12] = '{32'd1,          32'hFFFFFFFF,   32'd0,          32'd1,          1'b0};
        vecs[13] = '{32'hFFFFFFFF,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1};

        Reset    = 1'b0;
        Run      = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset quotient", 64'(Quotient), 64'd0);
        check("reset remainder", 64'(Remainder), 64'd0);
        check("reset ready", 64'(Ready), 64'd0);
        check("reset busy", 64'(Busy), 64'd0);
        check("reset divbyzero", 64'(DivByZero), 64'd0);
        @(negedge clk);
        Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle ready", 64'(Ready), 64'd0);
        check("idle busy", 64'(Busy), 64'd0);

        for (int i = 0; i < 14; i++) begin
            do_div($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dsr,
                   vecs[i].q, vecs[i].r, vecs[i].dbz);
        end

        // DONE holds indefinitely with Run low
        repeat (5) @(posedge clk);
        #1;
        check("hold ready", 64'(Ready), 64'd1);
        check("hold quotient", 64'(Quotient), 64'hFFFFFFFF);
        check("hold remainder", 64'(Remainder), 64'hFFFFFFFF);

        // Run held high across an operation; operand changes during ITER ignored
        @(negedge clk);
        Run      = 1'b1;
        Dividend = 32'd1000;
        Divisor  = 32'd3;
        @(posedge clk);
        #1;
        check("b2b start busy", 64'(Busy), 64'd1);
        @(negedge clk);
        Dividend = 32'd9;
        Divisor  = 32'd9;
        wait_ready("b2b first");
        check("b2b first quotient", 64'(Quotient), 64'd333);
        check("b2b first remainder", 64'(Remainder), 64'd1);
        @(posedge clk);
        #1;
        check("b2b restart ready", 64'(Ready), 64'd0);
        check("b2b restart busy", 64'(Busy), 64'd1);
        Run = 1'b0;
        wait_ready("b2b second");
        check("b2b second quotient", 64'(Quotient), 64'd1);
        check("b2b second remainder", 64'(Remainder), 64'd0);

        // Reset between edges in the middle of an operation
        @(negedge clk);
        Run      = 1'b1;
        Dividend = 32'd12345;
        Divisor  = 32'd67;
        @(posedge clk);
        #1;
        Run = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        Reset = 1'b0;
        #1;
        check("midrst quotient", 64'(Quotient), 64'd0);
        check("midrst remainder", 64'(Remainder), 64'd0);
        check("midrst ready", 64'(Ready), 64'd0);
        check("midrst busy", 64'(Busy), 64'd0);
        check("midrst divbyzero", 64'(DivByZero), 64'd0);
        @(negedge clk);
        Reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("postrst busy", 64'(Busy), 64'd0);
        check("postrst ready", 64'(Ready), 64'd0);
        do_div("postrst", 32'd12345, 32'd67, 32'd184, 32'd17, 1'b0);

        // Random pairs with biased corner values
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0)  b = b >> $urandom_range(0, 31);
            if (i % 5 == 0)  b = W'($urandom_range(0, 3));
            if (i % 7 == 0)  a = 32'hFFFFFFFF;
            if (i % 11 == 0) b = 32'hFFFFFFFF;
            if (i % 13 == 0) a = '0;
            if (i % 17 == 0) a = a >> $urandom_range(0, 31);
            if (b == '0) begin
                eq   = 32'hFFFFFFFF;
                er   = a;
                edbz = 1'b1;
            end else begin
                eq   = a / b;
                er   = a % b;
                edbz = 1'b0;
            end
            do_div($sformatf("rnd%0d", i), a, b, eq, er, edbz);
            if (b != '0) begin
                check($sformatf("rnd%0d identity", i),
                      64'(Quotient) * 64'(b) + 64'(Remainder), 64'(a));
                check($sformatf("rnd%0d rem<div", i), 64'(Remainder < b), 64'd1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
